shared_reg_arbiter: RTL

- Round-robin arbiter that shares one W-bit enabled register among N requesters.
- The register holds its value when not enabled and clears on synchronous reset.
- Each requester raises `req`, receives a one-hot `gnt`, and must hold its data stable through the grant cycle.
- The arbiter drives the register enable for exactly one cycle per accepted write, then pulses `ack` to the winner.

---
 rtl/shared_reg_arbiter_pkg.sv | 12 +
 rtl/shared_reg_arbiter_en_reg_w.sv | 33 +++
 rtl/shared_reg_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/shared_reg_arbiter_pkg.sv
// Shared constants for the round-robin shared-register arbiter.
// State encodings are plain localparams so the FSM reads as ordinary Verilog.
package shared_reg_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_ACK   = 2'd2;

  localparam int N_DEFAULT = 4;
  localparam int W_DEFAULT = 8;

endpackage

// File: rtl/shared_reg_arbiter_en_reg_w.sv
// W-bit enabled register: clears on synchronous reset, loads d when en,
// otherwise holds its value.
module en_reg_w #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (en) begin
      q_d = d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter sharing one W-bit register among N requesters.
// One write per accepted grant: IDLE -> GRANT (write) -> ACK -> IDLE.
//
// Handshake: a requester raises req[i] and holds req[i] and its wdata slice
// stable while gnt[i]=1; the write happens on the edge that ends GRANT only if
// req[i] is still high, and ack[i] then pulses for exactly one cycle.
module shared_reg_arbiter #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] wdata,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   ack,
  output logic [W-1:0]   q,
  output logic           busy
);

  import shared_reg_arbiter_pkg::*;

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] win_q, win_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [N-1:0]  ack_q, ack_d;
  logic          wr_en;
  logic [PW-1:0] pick;
  logic [W-1:0]  win_data;

  // First set request bit scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
  function automatic logic [PW-1:0] rr_pick(input logic [N-1:0] r,
                                            input logic [PW-1:0] p);
    logic          found;
    int            idx;
    logic [PW-1:0] res;
    found = 1'b0;
    res   = p;
    for (int o = 0; o < N; o++) begin
      idx = int'(p) + o;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (!found && r[idx]) begin
        res   = PW'(idx);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  // Explicit wrap keeps ptr inside 0..N-1 when N is not a power of two.
  function automatic logic [PW-1:0] ptr_after(input logic [PW-1:0] k);
    logic [PW-1:0] res;
    if (int'(k) == N - 1) begin
      res = '0;
    end else begin
      res = k + PW'(1);
    end
    return res;
  endfunction

  function automatic logic [N-1:0] onehot(input logic [PW-1:0] k);
    logic [N-1:0] res;
    res = '0;
    res[k] = 1'b1;
    return res;
  endfunction

  assign pick     = rr_pick(req, ptr_q);
  assign win_data = wdata[int'(win_q)*W +: W];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (req[win_q]) begin
          state_d = ST_ACK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt_d = '0;
    ack_d = '0;
    wr_en = 1'b0;
    ptr_d = ptr_q;
    win_d = win_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          win_d = pick;
          gnt_d = onehot(pick);
        end
      end
      ST_GRANT: begin
        // A withdrawn request aborts: no write, no ack, pointer unchanged.
        if (req[win_q]) begin
          wr_en = 1'b1;
          ack_d = onehot(win_q);
          ptr_d = ptr_after(win_q);
        end
      end
      default: begin
      end
    endcase
  end

  en_reg_w #(
    .W(W)
  ) u_reg (
    .clk  (clk),
    .reset(reset),
    .en   (wr_en),
    .d    (win_data),
    .q    (q)
  );

  assign gnt  = gnt_q;
  assign ack  = ack_q;
  assign busy = (state_q != ST_IDLE);

endmodule
